noc_recv_endpoint: RTL and testbench
====================================

// Module: noc_recv_endpoint
// PURPOSE
// Receive-side endpoint for one user receive port of the CONNECT-style NoC (Network).
// - Drains flits from recv_ports_N_getFlit, which is enabled every cycle.
// - Buffers them in per-VC FIFOs and delivers them packet-atomically to the user over a valid/ready port.
// - Returns one credit to recv_ports_N_putCredits per flit the user consumes.
// - Closes the credit loop that a free-draining sink leaves open.
// PARAMETERS
// FLIT_DATA_WIDTH  32  flit payload width; must match `FLIT_DATA_WIDTH
// NUM_VCS          2   virtual channels; must match `NUM_VCS
// NUM_RECV_PORTS   4   network receive ports; sets DEST_BITS = $clog2(NUM_RECV_PORTS)
// BUF_DEPTH        4   flits per VC FIFO; must equal the router's per-VC credit count
// Derived values:
// - VC_BITS = (NUM_VCS>1) ? $clog2(NUM_VCS) : 1
// - FLIT_W = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
// - CR_W = 1 + VC_BITS
// PORTS
// CLK           in   1                clock
// RST_N         in   1                reset, asynchronous, active-low
// flit_in       in   FLIT_W           {valid,tail,dest,vc,data} from recv_ports_N_getFlit
// credit_out    out  CR_W             {valid,vc} to recv_ports_N_putCredits_cr_in
// credit_en     out  1                to EN_recv_ports_N_putCredits; equals credit_out valid
// out_valid     out  1                user flit available
// out_ready     in   1                user accepts; pop occurs when out_valid & out_ready
// out_data      out  FLIT_DATA_WIDTH  payload of head flit
// out_tail      out  1                head flit is last of packet
// out_vc        out  VC_BITS          VC of head flit
// out_dest      out  DEST_BITS        dest field of head flit
// pkt_count     out  16               tails delivered to user; wraps 16'hFFFF->0
// overflow_err  out  1                sticky: a flit arrived at a full VC FIFO
// BEHAVIOUR
// Reset: async assert on RST_N=0. All outputs are 0, FIFOs empty, FSM in IDLE, RR pointer at VC0.
// - Reset mid-packet discards buffered flits and owed credits.
// - The Network must be reset together with this block.
// Enqueue:
// - A flit with flit_in[FLIT_W-1]=1 is written at the rising edge to the FIFO selected by its vc field.
// - Invalid flits are ignored.
// - The flit is visible at the outputs from the following cycle (1-cycle min latency).
// Full FIFO:
// - Push to a full FIFO with no pop of that VC in the same cycle: flit dropped, overflow_err set (sticky until reset).
// - Push and pop of the same full VC in the same cycle: push accepted, count unchanged, no error.
// Arbitration FSM (packet-atomic):
// - IDLE: grant the first non-empty VC at or after rr_ptr.
//   - Pop of a non-tail flit -> LOCKED(vc).
//   - Pop of a tail flit -> stay in IDLE, rr_ptr = vc+1 mod NUM_VCS.
// - LOCKED(v): out_* show VC v only.
//   - out_valid=0 while FIFO v is empty; other VCs are never interleaved.
//   - Pop of a tail flit -> IDLE, rr_ptr = v+1.
// - out_* are combinational from the granted FIFO head and hold stable while out_valid & !out_ready.
// Credits: each pop registers credit_out = {1'b1, popped vc} and credit_en = 1 for exactly the next cycle.
// - Otherwise credit_out = 0 and credit_en = 0.
// - At most one pop per cycle, so no credit merging is needed.
// - Dropped (overflow) flits return no credit.
// pkt_count: increments on each pop with out_tail=1; 16-bit wrap.
// Width rules:
// - FIFO pointers are $clog2(BUF_DEPTH) bits with an extra wrap bit for full/empty.
// - BUF_DEPTH must be a power of 2 and >= 2.
// STRUCTURE
// Shared include noc_defs.vh:
// - flit field offsets (VALID_POS, TAIL_POS, DEST/VC/DATA ranges)
// - VC_BITS / DEST_BITS / FLIT_W / CR_W derivation
// - used by the bench and by the sender side
// Sub-module noc_vc_fifo: one per VC via generate.
// - Ports: push, pop, din, dout, empty, full.
// - Data width = tail + dest + data bits; valid and vc are not stored.
// Top level contains the arbiter FSM, rr_ptr, credit register, pkt_count and overflow_err.
// TESTING
// 1. Reset held 5 cycles:
//    - all outputs 0 during reset and 1 cycle after release
//    - RST_N low mid-packet clears out_valid asynchronously
// 2. Single-flit packet {1,1,2'd2,1'b0,32'h10}, out_ready=1:
//    - out_valid with out_data=32'h10, out_tail=1 the next cycle
//    - credit_out=2'b10 one cycle after that
//    - pkt_count=1
// 3. Two-flit packet on VC1 (32'h11 non-tail, 32'h12 tail) interleaved with a 1-flit packet on VC0 (32'hFF):
//    - user sees 11,12 contiguous, then FF (or FF, then 11,12)
//    - never 11,FF,12
//    - two VC1 credits and one VC0 credit
// 4. out_ready=0, 4 flits to VC0:
//    - FIFO full, no credits emitted
//    - a 5th VC0 flit sets overflow_err and is dropped
//    - after releasing out_ready, exactly 4 flits and 4 credits
// 5. Full VC0 with simultaneous push and pop:
//    - no overflow_err
//    - occupancy stays 4
//    - the pushed flit is delivered in order
// 6. 65536 single-flit packets: pkt_count wraps to 0 and credit total = 65536.

Source files
------------

// File: rtl/noc_recv_endpoint_pkg.sv
// Shared types, defaults and flit-format helpers for the NoC receive endpoint.
// Flit layout (MSB..LSB): {valid, tail, dest, vc, data}.
package noc_recv_endpoint_pkg;

    localparam int FLIT_DATA_WIDTH_DEF = 32;
    localparam int NUM_VCS_DEF         = 2;
    localparam int NUM_RECV_PORTS_DEF  = 4;
    localparam int BUF_DEPTH_DEF       = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int vc_bits_of(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    function automatic int dest_bits_of(input int num_ports);
        return $clog2(num_ports);
    endfunction

    function automatic int flit_w_of(input int data_w, input int num_vcs, input int num_ports);
        return 2 + dest_bits_of(num_ports) + vc_bits_of(num_vcs) + data_w;
    endfunction

    function automatic int cr_w_of(input int num_vcs);
        return 1 + vc_bits_of(num_vcs);
    endfunction

endpackage

// File: rtl/noc_recv_endpoint_fifo.sv
// Per-VC flit FIFO. Pointers carry one extra wrap bit to tell full from empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module noc_vc_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign wr_ptr_d = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_en ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/noc_recv_endpoint.sv
// Receive endpoint: buffers network flits per VC, hands whole packets to the user
// over valid/ready, and returns one credit per consumed flit on the following cycle.
module noc_recv_endpoint
    import noc_recv_endpoint_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = FLIT_DATA_WIDTH_DEF,
    parameter int NUM_VCS         = NUM_VCS_DEF,
    parameter int NUM_RECV_PORTS  = NUM_RECV_PORTS_DEF,
    parameter int BUF_DEPTH       = BUF_DEPTH_DEF,
    localparam int DEST_BITS      = dest_bits_of(NUM_RECV_PORTS),
    localparam int VC_BITS        = vc_bits_of(NUM_VCS),
    localparam int FLIT_W         = flit_w_of(FLIT_DATA_WIDTH, NUM_VCS, NUM_RECV_PORTS),
    localparam int CR_W           = cr_w_of(NUM_VCS)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [FLIT_W-1:0]          flit_in,
    output logic [CR_W-1:0]            credit_out,
    output logic                       credit_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLIT_DATA_WIDTH-1:0] out_data,
    output logic                       out_tail,
    output logic [VC_BITS-1:0]         out_vc,
    output logic [DEST_BITS-1:0]       out_dest,
    output logic [15:0]                pkt_count,
    output logic                       overflow_err
);

    localparam int FIFO_W   = 1 + DEST_BITS + FLIT_DATA_WIDTH;
    localparam int VC_LSB   = FLIT_DATA_WIDTH;
    localparam int DEST_LSB = FLIT_DATA_WIDTH + VC_BITS;

    logic                       in_valid;
    logic                       in_tail;
    logic [DEST_BITS-1:0]       in_dest;
    logic [VC_BITS-1:0]         in_vc;
    logic [FLIT_DATA_WIDTH-1:0] in_data;

    assign in_valid = flit_in[FLIT_W-1];
    assign in_tail  = flit_in[FLIT_W-2];
    assign in_dest  = flit_in[DEST_LSB +: DEST_BITS];
    assign in_vc    = flit_in[VC_LSB +: VC_BITS];
    assign in_data  = flit_in[FLIT_DATA_WIDTH-1:0];

    logic [NUM_VCS-1:0] push;
    logic [NUM_VCS-1:0] pop_vc;
    logic [NUM_VCS-1:0] empty;
    logic [NUM_VCS-1:0] full;
    logic [NUM_VCS-1:0] drop;
    logic [FIFO_W-1:0]  head [NUM_VCS];

    arb_state_e           state_q, state_d;
    logic [VC_BITS-1:0]   lock_vc_q, lock_vc_d;
    logic [VC_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CR_W-1:0]      credit_q, credit_d;
    logic [15:0]          pkt_q, pkt_d;
    logic                 ovf_q, ovf_d;

    logic [VC_BITS-1:0]   grant;
    logic [VC_BITS-1:0]   cand;
    logic                 found;
    int                   idx;
    logic [FIFO_W-1:0]    head_sel;
    logic                 head_valid;
    logic                 head_tail;
    logic                 pop;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign push[v]   = in_valid && (in_vc == VC_BITS'(v));
        assign pop_vc[v] = pop && (grant == VC_BITS'(v));
        // A same-cycle pop of this VC makes room, so only an unrelieved full push is lost.
        assign drop[v]   = push[v] && full[v] && !pop_vc[v];

        noc_vc_fifo #(
            .WIDTH (FIFO_W),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .CLK   (CLK),
            .RST_N (RST_N),
            .push  (push[v]),
            .pop   (pop_vc[v]),
            .din   ({in_tail, in_dest, in_data}),
            .dout  (head[v]),
            .empty (empty[v]),
            .full  (full[v])
        );
    end

    always_comb begin
        grant = lock_vc_q;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        if (state_q == ARB_IDLE) begin
            grant = rr_ptr_q;
            for (int i = 0; i < NUM_VCS; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_VCS) begin
                    idx = idx - NUM_VCS;
                end
                cand = VC_BITS'(idx);
                if (!found && !empty[cand]) begin
                    found = 1'b1;
                    grant = cand;
                end
            end
        end
    end

    assign head_sel   = head[grant];
    assign head_valid = !empty[grant];
    assign head_tail  = head_sel[FIFO_W-1];
    assign pop        = head_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        credit_d  = '0;
        pkt_d     = pkt_q;
        ovf_d     = ovf_q || (|drop);
        if (pop) begin
            credit_d = {1'b1, grant};
            if (head_tail) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (grant == VC_BITS'(NUM_VCS - 1)) ? '0 : grant + VC_BITS'(1);
                pkt_d    = pkt_q + 16'd1;
            end else begin
                state_d   = ARB_LOCKED;
                lock_vc_d = grant;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ARB_IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            credit_q  <= '0;
            pkt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            credit_q  <= credit_d;
            pkt_q     <= pkt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Head fields are forced to zero when nothing is offered so idle outputs stay quiet.
    assign out_valid    = head_valid;
    assign out_data     = head_valid ? head_sel[FLIT_DATA_WIDTH-1:0] : '0;
    assign out_dest     = head_valid ? head_sel[FLIT_DATA_WIDTH +: DEST_BITS] : '0;
    assign out_tail     = head_valid && head_tail;
    assign out_vc       = head_valid ? grant : '0;
    assign credit_out   = credit_q;
    assign credit_en    = credit_q[CR_W-1];
    assign pkt_count    = pkt_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_noc_recv_endpoint.sv
// Directed bench for noc_recv_endpoint: a vector table for single/interleaved packets
// plus hand-written sequences for reset, overflow, full push+pop and counter wrap.
module tb_noc_recv_endpoint;
    import noc_recv_endpoint_pkg::*;

    localparam int DW     = FLIT_DATA_WIDTH_DEF;
    localparam int FLIT_W = flit_w_of(DW, NUM_VCS_DEF, NUM_RECV_PORTS_DEF);

    logic              CLK;
    logic              RST_N;
    logic [FLIT_W-1:0] flit_in;
    logic [1:0]        credit_out;
    logic              credit_en;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_tail;
    logic              out_vc;
    logic [1:0]        out_dest;
    logic [15:0]       pkt_count;
    logic              overflow_err;

    noc_recv_endpoint dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .flit_in      (flit_in),
        .credit_out   (credit_out),
        .credit_en    (credit_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tail     (out_tail),
        .out_vc       (out_vc),
        .out_dest     (out_dest),
        .pkt_count    (pkt_count),
        .overflow_err (overflow_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_err = 0;
    int credit_cnt = 0;

    always @(negedge CLK) begin
        if (credit_en) credit_cnt <= credit_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] pk(input logic v, input logic t, input logic [1:0] d,
                                             input logic vc, input logic [DW-1:0] data);
        return {v, t, d, vc, data};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({credit_out, credit_en, out_valid, out_data, out_tail, out_vc,
                    out_dest, pkt_count, overflow_err});
    endfunction

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    typedef struct {
        logic        fv;
        logic        ft;
        logic [1:0]  fd;
        logic        fvc;
        logic [31:0] fdata;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        et;
        logic        evc;
        logic [1:0]  edest;
        logic [1:0]  ecr;
        logic [15:0] epkt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int got;
        int c0;
        int waited;

        // single-flit packet on VC0, then VC1 two-flit packet interleaved with VC0 packet
        vecs[0] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 2'b00, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 2'd2, 2'b00, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 2'b10, 16'd1};
        vecs[3] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h11, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 2'b00, 16'd1};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'hFF, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 2'd1, 2'b00, 16'd1};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 1'b1, 32'h12, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 2'b11, 16'd1};
        vecs[6] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h12, 1'b1, 1'b1, 2'd1, 2'b00, 16'd1};
        vecs[7] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hFF, 1'b1, 1'b0, 2'd0, 2'b11, 16'd2};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 2'b10, 16'd3};
        vecs[9] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 2'b00, 16'd3};

        RST_N     = 1'b0;
        flit_in   = '0;
        out_ready = 1'b0;

        // reset held 5 cycles, outputs quiet during and one cycle after
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            #1 check("rst_hold_outs", all_outs(), 64'h0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        #1 check("rst_release_outs", all_outs(), 64'h0);
        @(negedge CLK);
        #1 check("rst_after1_outs", all_outs(), 64'h0);

        // mid-packet asynchronous reset
        @(negedge CLK);
        flit_in = pk(1'b1, 1'b0, 2'd1, 1'b1, 32'hAA);
        @(negedge CLK);
        flit_in = '0;
        #1 check("midpkt_valid_before", 64'(out_valid), 64'h1);
        #2 RST_N = 1'b0;
        #1 check("midpkt_async_clear", 64'(out_valid), 64'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1 check("midpkt_discarded", all_outs(), 64'h0);
        @(negedge CLK);

        for (int r = 0; r < 10; r++) begin
            flit_in   = pk(vecs[r].fv, vecs[r].ft, vecs[r].fd, vecs[r].fvc, vecs[r].fdata);
            out_ready = vecs[r].rdy;
            #1;
            check($sformatf("vec%0d_valid", r), 64'(out_valid), 64'(vecs[r].ev));
            check($sformatf("vec%0d_data", r), 64'(out_data), 64'(vecs[r].ed));
            check($sformatf("vec%0d_tail", r), 64'(out_tail), 64'(vecs[r].et));
            check($sformatf("vec%0d_vc", r), 64'(out_vc), 64'(vecs[r].evc));
            check($sformatf("vec%0d_dest", r), 64'(out_dest), 64'(vecs[r].edest));
            check($sformatf("vec%0d_credit", r), 64'(credit_out), 64'(vecs[r].ecr));
            check($sformatf("vec%0d_credit_en", r), 64'(credit_en), 64'(vecs[r].ecr[1]));
            check($sformatf("vec%0d_pkt", r), 64'(pkt_count), 64'(vecs[r].epkt));
            @(negedge CLK);
        end
        flit_in = '0;

        // fill VC0 with out_ready low, then overflow with a fifth flit
        out_ready = 1'b0;
        c0 = credit_cnt;
        for (int k = 0; k < 4; k++) begin
            flit_in = pk(1'b1, 1'b1, 2'd3, 1'b0, 32'h40 + 32'(k));
            #1 check("fill_no_credit", 64'(credit_en), 64'h0);
            @(negedge CLK);
        end
        flit_in = pk(1'b1, 1'b1, 2'd3, 1'b0, 32'h44);
        #1 check("fill_no_ovf_yet", 64'(overflow_err), 64'h0);
        @(negedge CLK);
        flit_in = '0;
        #1 check("ovf_set", 64'(overflow_err), 64'h1);
        check("ovf_head", 64'(out_data), 64'h40);
        check("fill_credits_none", 64'(credit_cnt - c0), 64'h0);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (out_valid) begin
                check("ovf_drain_data", 64'(out_data), 64'h40 + 64'(got));
                got++;
            end
            @(negedge CLK);
            #1;
        end
        check("ovf_drain_count", 64'(got), 64'd4);
        check("ovf_drain_credits", 64'(credit_cnt - c0), 64'd4);
        check("ovf_sticky", 64'(overflow_err), 64'h1);

        // full VC0 with simultaneous push and pop
        @(negedge CLK);
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            flit_in = pk(1'b1, 1'b1, 2'd0, 1'b0, 32'h50 + 32'(k));
            @(negedge CLK);
        end
        c0 = credit_cnt;
        flit_in   = pk(1'b1, 1'b1, 2'd0, 1'b0, 32'h54);
        out_ready = 1'b1;
        #1 check("pp_head_before", 64'(out_data), 64'h50);
        @(negedge CLK);
        flit_in   = '0;
        out_ready = 1'b0;
        #1 check("pp_no_ovf", 64'(overflow_err), 64'h0);
        check("pp_head_after", 64'(out_data), 64'h51);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (out_valid) begin
                check("pp_drain_data", 64'(out_data), 64'h51 + 64'(got));
                got++;
            end
            @(negedge CLK);
            #1;
        end
        check("pp_drain_count", 64'(got), 64'd4);
        check("pp_credits", 64'(credit_cnt - c0), 64'd5);
        check("pp_pkt", 64'(pkt_count), 64'd5);

        // 65536 single-flit packets: pkt_count wraps, credits all returned
        @(negedge CLK);
        do_reset();
        out_ready = 1'b1;
        c0 = credit_cnt;
        for (int i = 0; i < 65536; i++) begin
            flit_in = pk(1'b1, 1'b1, 2'(i), 1'(i), 32'(i));
            @(negedge CLK);
        end
        flit_in = '0;
        waited = 0;
        while ((credit_cnt - c0) < 65536 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        #1;
        check("wrap_credit_total", 64'(credit_cnt - c0), 64'd65536);
        check("wrap_pkt_count", 64'(pkt_count), 64'h0);
        check("wrap_no_ovf", 64'(overflow_err), 64'h0);
        check("wrap_idle", 64'(out_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
